relu_maxpool: RTL
=================

# relu_maxpool

Downstream stage of the 3×3 convolution engine. Consumes the convolution's 32-bit signed result stream and its `valid` qualifier, applies ReLU, then 2×2/stride-2 max pooling over the valid output map (26×26 for 28×28 MNIST input). It emits one pooled value per 2×2 window (13×13 per frame) to the dense/classifier stage. There is no backpressure: input is accepted whenever `valid_in` is high.

## Interface
- `W`, 26: valid convolution columns per row; must be even (elaboration error otherwise).
- `H`, 26: valid convolution rows per frame; must be even (elaboration error otherwise).
- `DW`, 32: sample width, two's-complement.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `pxl_in`  in  DW  signed convolution result; sampled only when `valid_in`=1.
- `valid_in`  in  1  qualifier from the conv block; arbitrary gaps allowed.
- `pxl_out`  out  DW  pooled value, always ≥0; held between pulses.
- `valid_out`  out  1  one-cycle pulse per pooled value.
- `frame_done`  out  1  one-cycle pulse coincident with the last `valid_out` of a frame.
- `col`  out  $clog2(W)  column index of the next expected sample.
- `row`  out  $clog2(H)  row index of the next expected sample.

## Operation
- ReLU: r = (pxl_in[DW-1]) ? 0 : pxl_in. After ReLU all compares are unsigned.
- Counters advance only on `valid_in`:
  - `col` counts 0..W-1; at W-1 it wraps to 0 and `row` increments.
  - `row` counts 0..H-1; at (H-1, W-1) both wrap to 0.
- Even `col`: store r in the horizontal holding register `hold`.
- Odd `col`: m = max(hold, r).
  - Even `row`: write m into line buffer `lb[col>>1]` (W/2 entries × DW).
  - Odd `row`: `pxl_out` <= max(`lb[col>>1]`, m) and `valid_out` <= 1.
- `frame_done` <= 1 on the same edge as `valid_out` for the sample at (H-1, W-1).
- Line-buffer entries are overwritten each even row. No clearing between frames is required, since every entry is written before it is read.
- No gaps between frames are required: the sample after (H-1, W-1) is (0, 0) of the next frame.
- Reset mid-frame discards the partial frame. The next `valid_in` after reset release is (0, 0). No pulse is produced for the discarded windows.

## Timing
- Reset values: `pxl_out`=0, `valid_out`=0, `frame_done`=0, `col`=0, `row`=0, `hold`=0. Line-buffer contents are don't-care.
- Latency: `valid_out` and the new `pxl_out` appear on the first rising edge after the (odd row, odd col) input sample, i.e. 1 cycle.
- `valid_out` and `frame_done` are high for exactly one cycle per event, even when `valid_in` is held high continuously.
- Throughput: one input per cycle sustained. Output pulses are at most one every 2 cycles, and only during odd rows.
- `col`/`row` update on the same edge that consumes the sample.
- Reset asserted on the same edge as a would-be output: reset wins, and no pulse is produced.
- `pxl_in` is ignored whenever `valid_in`=0.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs 0 immediately, with no clock edge required. Release; idle 10 cycles -> no pulses.
- W=4, H=4, contiguous `valid_in`, pxl_in = 0..15 raster order -> `valid_out` pulses carrying 5, 7, 13, 15. `frame_done` fires only with 15. Each pulse is 1 cycle after samples 5, 7, 13, 15.
- W=4, H=4, all samples negative (−1, 0x80000000 mixed) -> four pulses, all `pxl_out`=0. Single window {0x7FFFFFFF, −5, 0, 3} -> 0x7FFFFFFF.
- W=4, H=4, `valid_in` high 1 cycle in 3, ramp 0..15 -> same 5, 7, 13, 15 values. Pulses stay 1 cycle wide. `col`/`row` frozen during gaps.
- W=4, H=4, `reset` pulse after 6 samples, then a full 0..15 frame -> exactly four pulses carrying 5, 7, 13, 15. No stale line-buffer influence.
- Defaults (26×26), two back-to-back frames of random signed values vs. reference model -> 169 pulses per frame, all values matching. `frame_done` fires exactly twice. Counters return to 0/0.

Source files
------------

// File: rtl/relu_maxpool_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : relu_maxpool_if
// Description : Sample stream from the convolution engine into the
//               ReLU / 2x2 max-pool stage, plus the pooled result stream
//               and the position counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface relu_maxpool_if #(
    parameter int W  = 26,
    parameter int H  = 26,
    parameter int DW = 32
);
    logic [DW-1:0]         pxl_in;
    logic                  valid_in;
    logic [DW-1:0]         pxl_out;
    logic                  valid_out;
    logic                  frame_done;
    logic [$clog2(W)-1:0]  col;
    logic [$clog2(H)-1:0]  row;

    // Producer side: the convolution engine (or a bench driving it).
    modport master (
        output pxl_in, valid_in,
        input  pxl_out, valid_out, frame_done, col, row
    );

    // Consumer side: the pooling stage itself.
    modport slave (
        input  pxl_in, valid_in,
        output pxl_out, valid_out, frame_done, col, row
    );
endinterface
`default_nettype wire

// File: rtl/relu_maxpool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : relu_maxpool
// Description : ReLU followed by 2x2 / stride-2 max pooling over a W x H
//               valid convolution map. One pooled value per window; no
//               backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool #(
    parameter int W  = 26,
    parameter int H  = 26,
    parameter int DW = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    relu_maxpool_if.slave bus
);
    localparam int c_CW = $clog2(W);
    localparam int c_RW = $clog2(H);

    // The line-buffer index is col with its LSB dropped, so the map must be
    // even-sized in both directions (and at least two windows wide).
    if ((W % 2) != 0 || W < 4) begin : g_bad_w
        $error("relu_maxpool: W must be even and >= 4");
    end
    if ((H % 2) != 0 || H < 2) begin : g_bad_h
        $error("relu_maxpool: H must be even and >= 2");
    end

    // One entry per window column: horizontal max of the even row.
    logic [DW-1:0]   r_lb [W/2];

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic [DW-1:0]   r_hold;
    logic [DW-1:0]   r_pxl_out;
    logic            r_valid_out;
    logic            r_frame_done;

    logic [DW-1:0]   w_relu;
    logic [DW-1:0]   w_hmax;
    logic [DW-1:0]   w_lb_rd;
    logic [DW-1:0]   w_pool;
    logic [c_CW-2:0] w_lb_idx;
    logic            w_last_col;
    logic            w_last_row;

    // After ReLU every value is non-negative, so unsigned compares suffice.
    assign w_relu     = bus.pxl_in[DW-1] ? '0 : bus.pxl_in;
    assign w_hmax     = (w_relu > r_hold) ? w_relu : r_hold;
    assign w_lb_idx   = r_col[c_CW-1:1];
    assign w_lb_rd    = r_lb[w_lb_idx];
    assign w_pool     = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;
    assign w_last_col = (r_col == c_CW'(W - 1));
    assign w_last_row = (r_row == c_RW'(H - 1));

    // Raster position of the next expected sample; moves only on valid_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.valid_in) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Horizontal hold on even columns; pooled output on odd row / odd col.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold       <= '0;
            r_pxl_out    <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.valid_in) begin
                if (!r_col[0]) begin
                    r_hold <= w_relu;
                end else if (r_row[0]) begin
                    r_pxl_out    <= w_pool;
                    r_valid_out  <= 1'b1;
                    r_frame_done <= w_last_row & w_last_col;
                end
            end
        end
    end

    // Line buffer: written on even rows, always written before it is read,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (bus.valid_in && r_col[0] && !r_row[0]) begin
            r_lb[w_lb_idx] <= w_hmax;
        end
    end

    assign bus.pxl_out    = r_pxl_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.frame_done = r_frame_done;
    assign bus.col        = r_col;
    assign bus.row        = r_row;
endmodule
`default_nettype wire
